// File: rtl/sram_axi_bridge_if.sv
// AXI3 single-beat master/slave signal bundle used by sram_axi_bridge.
// The bridge drives the address/write channels and consumes R and B.
interface sram_axi_bridge_if #(
    parameter int DW   = 32,
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [2:0]      arsize;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [DW-1:0]   rdata;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [2:0]      awsize;
    logic            awvalid;
    logic            awready;

    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arsize, arvalid,
        input  arready,
        input  rid, rdata, rvalid,
        output rready,
        output awid, awaddr, awsize, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bid, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arsize, arvalid,
        output arready,
        output rid, rdata, rvalid,
        input  rready,
        input  awid, awaddr, awsize, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bid, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridge from NCH SRAM-like request channels onto one AXI3 master port.
// Round-robin arbitration across channels, one read and one write in flight,
// one outstanding transaction per channel, reads stalled on a RAW word match.
module sram_axi_bridge #(
    parameter int NCH  = 2,
    parameter int DW   = 32,
    parameter int ID_W = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NCH-1:0]        m_req,
    input  logic [NCH-1:0]        m_wr,
    input  logic [2*NCH-1:0]      m_size,
    input  logic [32*NCH-1:0]     m_addr,
    input  logic [(DW/8)*NCH-1:0] m_wstrb,
    input  logic [DW*NCH-1:0]     m_wdata,
    output logic [NCH-1:0]        m_addr_ok,
    output logic [NCH-1:0]        m_data_ok,
    output logic [DW-1:0]         m_rdata,
    sram_axi_bridge_if.master     axi
);

    localparam int SW    = DW / 8;
    localparam int OFS   = $clog2(SW);
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_t;

    r_state_t         r_state, r_next;
    w_state_t         w_state, w_next;

    logic [NCH-1:0]   busy;
    logic [PTR_W-1:0] rr_ptr;

    logic [ID_W-1:0]  ar_id_q;
    logic [31:0]      ar_addr_q;
    logic [2:0]       ar_size_q;
    logic [ID_W-1:0]  aw_id_q;
    logic [31:0]      aw_addr_q;
    logic [2:0]       aw_size_q;
    logic [DW-1:0]    w_data_q;
    logic [SW-1:0]    w_strb_q;
    logic             aw_done;
    logic             w_done;

    logic             r_done;
    logic             b_done;
    logic             r_free;
    logic             w_free;
    logic [NCH-1:0]   elig;
    logic             grant_any;
    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_rd;
    logic             grant_wr;

    // An FSM that completes this cycle counts as free so a new grant can follow immediately
    assign r_done = (r_state == R_R) && axi.rvalid;
    assign b_done = (w_state == W_B) && axi.bvalid;
    assign r_free = (r_state == R_IDLE) || r_done;
    assign w_free = (w_state == W_IDLE) || b_done;

    // Per-channel eligibility, including the read-after-write word-address stall
    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m_req[i] && !busy[i]) begin
                if (m_wr[i]) begin
                    elig[i] = w_free;
                end else begin
                    elig[i] = r_free &&
                              !(!w_free && (m_addr[i*32+OFS +: 32-OFS] == aw_addr_q[31:OFS]));
                end
            end
        end
    end

    // Round-robin search starting at rr_ptr; at most one grant per cycle
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (!grant_any && elig[idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
        grant_valid = grant_any && resetn;
        grant_rd    = grant_valid && !m_wr[grant_idx];
        grant_wr    = grant_valid &&  m_wr[grant_idx];
    end

    // Channel-side strobes: accept pulse for the granted channel, completion pulses routed by ID
    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < NCH; i++) begin
            m_addr_ok[i] = grant_valid && (grant_idx == PTR_W'(i));
            m_data_ok[i] = (r_done && (axi.rid == ID_W'(i))) ||
                           (b_done && (axi.bid == ID_W'(i)));
        end
    end

    assign m_rdata = axi.rdata;

    // Busy flags track each channel's single outstanding transaction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy   <= '0;
            rr_ptr <= '0;
        end else begin
            busy <= (busy & ~m_data_ok) | m_addr_ok;
            if (grant_valid) begin
                rr_ptr <= (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Capture the granted request fields so the AXI side stays stable until handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            ar_size_q <= '0;
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            aw_size_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (grant_rd) begin
                ar_id_q   <= ID_W'(grant_idx);
                ar_addr_q <= m_addr[int'(grant_idx)*32 +: 32];
                ar_size_q <= {1'b0, m_size[int'(grant_idx)*2 +: 2]};
            end
            if (grant_wr) begin
                aw_id_q   <= ID_W'(grant_idx);
                aw_addr_q <= m_addr[int'(grant_idx)*32 +: 32];
                aw_size_q <= {1'b0, m_size[int'(grant_idx)*2 +: 2]};
                w_data_q  <= m_wdata[int'(grant_idx)*DW +: DW];
                w_strb_q  <= m_wstrb[int'(grant_idx)*SW +: SW];
            end
        end
    end

    // FSM state registers plus the independent AW/W completion flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
            if (w_state == W_REQ && w_next != W_REQ) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (w_state == W_REQ) begin
                if (axi.awready) aw_done <= 1'b1;
                if (axi.wready)  w_done  <= 1'b1;
            end
        end
    end

    // Read FSM: AR handshake, then wait for the single R beat
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (grant_rd) r_next = R_AR;
            R_AR:    if (axi.arready) r_next = R_R;
            R_R:     if (axi.rvalid) r_next = grant_rd ? R_AR : R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Write FSM: AW and W complete independently, then wait for B
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (grant_wr) w_next = W_REQ;
            W_REQ:   if ((aw_done || axi.awready) && (w_done || axi.wready)) w_next = W_B;
            W_B:     if (axi.bvalid) w_next = grant_wr ? W_REQ : W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // AXI channel outputs decoded from FSM state and latched fields
    always_comb begin
        axi.arid    = ar_id_q;
        axi.araddr  = ar_addr_q;
        axi.arsize  = ar_size_q;
        axi.arvalid = (r_state == R_AR);
        axi.rready  = (r_state == R_R);
        axi.awid    = aw_id_q;
        axi.awaddr  = aw_addr_q;
        axi.awsize  = aw_size_q;
        axi.awvalid = (w_state == W_REQ) && !aw_done;
        axi.wdata   = w_data_q;
        axi.wstrb   = w_strb_q;
        axi.wvalid  = (w_state == W_REQ) && !w_done;
        axi.bready  = (w_state == W_B);
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed self-checking bench for sram_axi_bridge with NCH=2, DW=32.
// Inputs change 1ns after the rising edge; outputs are sampled 3ns after it.
module tb_sram_axi_bridge;

    localparam int NCH  = 2;
    localparam int DW   = 32;
    localparam int ID_W = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  m_req;
    logic [1:0]  m_wr;
    logic [3:0]  m_size;
    logic [63:0] m_addr;
    logic [7:0]  m_wstrb;
    logic [63:0] m_wdata;
    logic [1:0]  m_addr_ok;
    logic [1:0]  m_data_ok;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;
    int e;
    int prev;

    sram_axi_bridge_if #(.DW(DW), .ID_W(ID_W)) axi ();

    sram_axi_bridge #(.NCH(NCH), .DW(DW), .ID_W(ID_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_addr    (m_addr),
        .m_wstrb   (m_wstrb),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata),
        .axi       (axi)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] wr,
                                 input logic [31:0] a0, input logic [31:0] a1);
        m_req  = req;
        m_wr   = wr;
        m_addr = {a1, a0};
    endtask

    task automatic slaveIdle();
        axi.arready = 1'b0;
        axi.rid     = '0;
        axi.rdata   = '0;
        axi.rvalid  = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bid     = '0;
        axi.bvalid  = 1'b0;
    endtask

    function automatic logic [4:0] valids();
        return {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        resetn  = 1'b0;
        m_size  = 4'b1010;
        m_wstrb = '0;
        m_wdata = '0;
        applyStimulus(2'b11, 2'b00, 32'h1000, 32'h1100);
        slaveIdle();
        @(posedge clk);
        @(posedge clk);
        #3;
        checkOutput("reset_addr_ok", m_addr_ok, 2'b00);
        checkOutput("reset_valids", valids(), 5'b0);
        checkOutput("reset_data_ok", m_data_ok, 2'b00);
        applyStimulus(2'b00, 2'b00, 0, 0);
        cycle();
        resetn = 1'b1;

        // Single read on channel 0
        cycle(); applyStimulus(2'b01, 2'b00, 32'h1000, 0); settle();
        checkOutput("rd_addr_ok", m_addr_ok, 2'b01);
        checkOutput("rd_data_ok_t0", m_data_ok, 2'b00);
        cycle(); applyStimulus(2'b00, 2'b00, 0, 0); axi.arready = 1'b1; settle();
        checkOutput("rd_arvalid", axi.arvalid, 1'b1);
        checkOutput("rd_araddr", axi.araddr, 32'h1000);
        checkOutput("rd_arid", axi.arid, 0);
        checkOutput("rd_arsize", axi.arsize, 3'd2);
        cycle(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rid = 0; axi.rdata = 32'hDEADBEEF; settle();
        checkOutput("rd_rready", axi.rready, 1'b1);
        checkOutput("rd_data_ok", m_data_ok, 2'b01);
        checkOutput("rd_rdata", m_rdata, 32'hDEADBEEF);
        cycle(); axi.rvalid = 1'b0; settle();
        checkOutput("rd_data_ok_pulse", m_data_ok, 2'b00);
        checkOutput("rd_rready_idle", axi.rready, 1'b0);

        // Both channels read continuously; pointer starts at 1 after the previous grant
        axi.arready = 1'b1;
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            e = (n % 2 == 0) ? 1 : 0;
            cycle(); applyStimulus(2'b11, 2'b00, 32'h100, 32'h200);
            if (n > 0) begin
                axi.rvalid = 1'b1;
                axi.rid    = ID_W'(prev);
                axi.rdata  = 32'hA0000000 + 32'(prev);
            end
            settle();
            checkOutput($sformatf("rr_grant%0d", n), m_addr_ok, 64'(1 << e));
            if (n > 0) begin
                checkOutput($sformatf("rr_data_ok%0d", n), m_data_ok, 64'(1 << prev));
                checkOutput($sformatf("rr_rdata%0d", n), m_rdata, 32'hA0000000 + 32'(prev));
            end
            cycle(); axi.rvalid = 1'b0; settle();
            checkOutput($sformatf("rr_arid%0d", n), axi.arid, e);
            checkOutput($sformatf("rr_araddr%0d", n), axi.araddr, (e == 1) ? 32'h200 : 32'h100);
            checkOutput($sformatf("rr_hold%0d", n), m_addr_ok, 2'b00);
            prev = e;
        end
        cycle(); applyStimulus(2'b00, 2'b00, 0, 0);
        axi.rvalid = 1'b1; axi.rid = ID_W'(prev); axi.rdata = 32'hA0000000 + 32'(prev); settle();
        checkOutput("rr_last_data_ok", m_data_ok, 2'b01);
        checkOutput("rr_last_no_grant", m_addr_ok, 2'b00);
        cycle(); axi.rvalid = 1'b0; axi.arready = 1'b0;

        // Channel 1 write with W accepted three cycles after AW
        cycle(); applyStimulus(2'b10, 2'b10, 0, 32'h2000);
        m_wdata = {32'h12345678, 32'h0}; m_wstrb = 8'hF0; settle();
        checkOutput("wr_addr_ok", m_addr_ok, 2'b10);
        cycle(); applyStimulus(2'b00, 2'b00, 0, 0); m_wdata = '0; m_wstrb = '0; axi.awready = 1'b1; settle();
        checkOutput("wr_awvalid", axi.awvalid, 1'b1);
        checkOutput("wr_wvalid", axi.wvalid, 1'b1);
        checkOutput("wr_awaddr", axi.awaddr, 32'h2000);
        checkOutput("wr_awid", axi.awid, 1);
        checkOutput("wr_awsize", axi.awsize, 3'd2);
        checkOutput("wr_wdata", axi.wdata, 32'h12345678);
        checkOutput("wr_wstrb", axi.wstrb, 4'hF);
        cycle(); axi.awready = 1'b0; settle();
        checkOutput("wr_aw_once", axi.awvalid, 1'b0);
        checkOutput("wr_w_held", axi.wvalid, 1'b1);
        cycle(); settle();
        checkOutput("wr_w_held2", axi.wvalid, 1'b1);
        checkOutput("wr_no_bready", axi.bready, 1'b0);
        cycle(); axi.wready = 1'b1; settle();
        checkOutput("wr_w_hs", axi.wvalid, 1'b1);
        cycle(); axi.wready = 1'b0; settle();
        checkOutput("wr_w_once", axi.wvalid, 1'b0);
        checkOutput("wr_bready", axi.bready, 1'b1);
        checkOutput("wr_no_early_ok", m_data_ok, 2'b00);
        cycle(); axi.bvalid = 1'b1; axi.bid = 1; settle();
        checkOutput("wr_data_ok", m_data_ok, 2'b10);
        cycle(); axi.bvalid = 1'b0; settle();
        checkOutput("wr_data_ok_pulse", m_data_ok, 2'b00);
        checkOutput("wr_bready_idle", axi.bready, 1'b0);

        // RAW stall: write to 0x3004 pending, unrelated read proceeds, matching read waits for B
        cycle(); applyStimulus(2'b10, 2'b10, 0, 32'h3004);
        m_wdata = {32'h00000044, 32'h0}; m_wstrb = 8'hF0; settle();
        checkOutput("raw_wr_grant", m_addr_ok, 2'b10);
        cycle(); applyStimulus(2'b01, 2'b00, 32'h4000, 0); settle();
        checkOutput("raw_other_grant", m_addr_ok, 2'b01);
        checkOutput("raw_awvalid", axi.awvalid, 1'b1);
        cycle(); applyStimulus(2'b00, 2'b00, 0, 0); axi.arready = 1'b1; settle();
        checkOutput("raw_other_araddr", axi.araddr, 32'h4000);
        cycle(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rid = 0; axi.rdata = 32'hCAFE0000; settle();
        checkOutput("raw_other_data_ok", m_data_ok, 2'b01);
        cycle(); axi.rvalid = 1'b0; applyStimulus(2'b01, 2'b00, 32'h3006, 0);
        axi.awready = 1'b1; axi.wready = 1'b1; settle();
        checkOutput("raw_stall_word", m_addr_ok, 2'b00);
        cycle(); axi.awready = 1'b0; axi.wready = 1'b0; applyStimulus(2'b01, 2'b00, 32'h3004, 0); settle();
        checkOutput("raw_stall_b1", m_addr_ok, 2'b00);
        checkOutput("raw_bready", axi.bready, 1'b1);
        cycle(); settle();
        checkOutput("raw_stall_b2", m_addr_ok, 2'b00);
        cycle(); axi.bvalid = 1'b1; axi.bid = 1; settle();
        checkOutput("raw_b_data_ok", m_data_ok, 2'b10);
        checkOutput("raw_release", m_addr_ok, 2'b01);
        cycle(); axi.bvalid = 1'b0; applyStimulus(2'b00, 2'b00, 0, 0); axi.arready = 1'b1; settle();
        checkOutput("raw_arvalid", axi.arvalid, 1'b1);
        checkOutput("raw_araddr", axi.araddr, 32'h3004);
        cycle(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rid = 0; axi.rdata = 32'h55AA55AA; settle();
        checkOutput("raw_rd_data_ok", m_data_ok, 2'b01);
        checkOutput("raw_rd_rdata", m_rdata, 32'h55AA55AA);
        cycle(); axi.rvalid = 1'b0;

        // Concurrent read and write finishing in the same cycle
        cycle(); applyStimulus(2'b11, 2'b10, 32'h5000, 32'h6000);
        m_wdata = {32'hA5A5A5A5, 32'h0}; m_wstrb = 8'h30; settle();
        checkOutput("cc_wr_grant", m_addr_ok, 2'b10);
        cycle(); applyStimulus(2'b01, 2'b00, 32'h5000, 0); axi.awready = 1'b1; axi.wready = 1'b1; settle();
        checkOutput("cc_rd_grant", m_addr_ok, 2'b01);
        checkOutput("cc_wstrb", axi.wstrb, 4'h3);
        checkOutput("cc_wdata", axi.wdata, 32'hA5A5A5A5);
        cycle(); applyStimulus(2'b00, 2'b00, 0, 0); axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b1; settle();
        checkOutput("cc_arvalid", axi.arvalid, 1'b1);
        checkOutput("cc_bready", axi.bready, 1'b1);
        cycle(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rid = 0; axi.rdata = 32'h0BADF00D;
        axi.bvalid = 1'b1; axi.bid = 1; settle();
        checkOutput("cc_data_ok_both", m_data_ok, 2'b11);
        checkOutput("cc_rdata", m_rdata, 32'h0BADF00D);
        cycle(); axi.rvalid = 1'b0; axi.bvalid = 1'b0; settle();
        checkOutput("cc_data_ok_clear", m_data_ok, 2'b00);

        // Asynchronous reset while waiting for read data
        cycle(); applyStimulus(2'b01, 2'b00, 32'h7000, 0); settle();
        checkOutput("rst_rd_grant", m_addr_ok, 2'b01);
        cycle(); applyStimulus(2'b00, 2'b00, 0, 0); axi.arready = 1'b1; settle();
        checkOutput("rst_arvalid", axi.arvalid, 1'b1);
        cycle(); axi.arready = 1'b0; settle();
        checkOutput("rst_in_rr", axi.rready, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("rst_async_valids", valids(), 5'b0);
        checkOutput("rst_async_data_ok", m_data_ok, 2'b00);
        axi.rvalid = 1'b1; axi.rid = 0; axi.rdata = 32'h11111111;
        #1;
        checkOutput("rst_no_data_ok", m_data_ok, 2'b00);
        cycle(); axi.rvalid = 1'b0; resetn = 1'b1;
        axi.rvalid = 1'b1;
        #1;
        checkOutput("rst_stale_data_ok", m_data_ok, 2'b00);
        cycle(); axi.rvalid = 1'b0; applyStimulus(2'b11, 2'b00, 32'h8000, 32'h9000); settle();
        checkOutput("rst_rr_ptr_zero", m_addr_ok, 2'b01);
        checkOutput("rst_post_data_ok", m_data_ok, 2'b00);
        cycle(); applyStimulus(2'b00, 2'b00, 0, 0); axi.arready = 1'b1; settle();
        checkOutput("rst_post_arid", axi.arid, 0);
        checkOutput("rst_post_araddr", axi.araddr, 32'h8000);
        cycle(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rid = 0; axi.rdata = 32'h88888888; settle();
        checkOutput("rst_post_data_ok_fire", m_data_ok, 2'b01);
        checkOutput("rst_post_rdata", m_rdata, 32'h88888888);
        cycle(); axi.rvalid = 1'b0; settle();
        checkOutput("rst_post_done", m_data_ok, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
